// File: rtl/sram_1r1w_init.sv
// 1-read / 1-write SRAM with lane write mask and a zero-clearing sweep after reset.
// Optional macro SRAM_RW_BYPASS_EN: same-address read/write returns write-first data (default read-first).
module sram_1r1w_init #(
  parameter int DATA_W    = 152,
  parameter int DEPTH     = 128,
  parameter int MASK_GRAN = 8,
  localparam int NLANE    = DATA_W / MASK_GRAN,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic [DATA_W-1:0] R0_data,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [NLANE-1:0]  W0_mask,
  input  logic [DATA_W-1:0] W0_data,
  output logic              init_done
);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] w_bits;
  logic              r_in_range;
  logic              w_in_range;
  logic [DATA_W-1:0] r_old;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wbits;

  // Expand the per-lane mask into a per-bit mask.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_bits = '0;
    for (int k = 0; k < NLANE; k++) begin
      w_bits[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[k]}};
    end
  end

  always_comb begin
    r_in_range = {1'b0, R0_addr} < DEPTH_X;
    w_in_range = {1'b0, W0_addr} < DEPTH_X;
    r_old      = r_in_range ? mem[R0_addr] : '0;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic: the sweep ends on the cycle that clears the last entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_IDLE: ;
    endcase
  end

  // Output logic: array write port and read-data register input.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = W0_addr;
    mem_wdata = W0_data;
    mem_wbits = w_bits;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wbits = '1;
      end
      ST_IDLE: begin
        mem_we = W0_en && w_in_range;
        if (R0_en) begin
          rdata_d = r_old;
`ifdef SRAM_RW_BYPASS_EN
          if (W0_en && w_in_range && (R0_addr == W0_addr)) begin
            rdata_d = (r_old & ~w_bits) | (W0_data & w_bits);
          end
`endif
        end
      end
    endcase
  end

  // NOTE: the array has no reset; it is cleared only by the post-reset sweep.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wbits) | (mem_wdata & mem_wbits);
    end
  end

  assign R0_data   = rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_1r1w_init.sv
// Randomized bench for sram_1r1w_init: DEPTH=128 and DEPTH=100 instances share stimulus
// and are checked every cycle against a behavioural array model.
module tb_sram_1r1w_init;

  localparam int DW = 152;
  localparam int NL = 19;
  localparam int AW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          r_en = 1'b0, w_en = 1'b0;
  logic [AW-1:0] r_addr = '0, w_addr = '0;
  logic [NL-1:0] w_mask = '0;
  logic [DW-1:0] w_data = '0;

  logic [DW-1:0] rd_a, rd_b;
  logic          done_a, done_b;

  always #5 clock = ~clock;

  sram_1r1w_init dut_a (
    .clock(clock), .reset(reset),
    .R0_en(r_en), .R0_addr(r_addr), .R0_data(rd_a),
    .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask), .W0_data(w_data),
    .init_done(done_a)
  );

  sram_1r1w_init #(.DEPTH(100)) dut_b (
    .clock(clock), .reset(reset),
    .R0_en(r_en), .R0_addr(r_addr), .R0_data(rd_b),
    .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask), .W0_data(w_data),
    .init_done(done_b)
  );

  // Model: per instance, cycles since reset release, contents, and expected outputs.
  int            mdepth [2] = '{128, 100};
  logic [DW-1:0] mmem   [2][128];
  int            mcyc   [2];
  logic [DW-1:0] exp_rd [2];
  logic          exp_done [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] lane_bits(input logic [NL-1:0] m);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < NL; k++) b[k*8 +: 8] = {8{m[k]}};
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] t;
    t = '0;
    for (int k = 0; k < 5; k++) t = {t[127:0], 32'($urandom)};
    return t[DW-1:0];
  endfunction

  // Advance the model by the upcoming rising edge, using the inputs just driven.
  task automatic model_step();
    logic [DW-1:0] bits, old;
    logic          wr_ok;
    bits = lane_bits(w_mask);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mcyc[i]     = 0;
        exp_done[i] = 1'b0;
        exp_rd[i]   = '0;
        for (int j = 0; j < 128; j++) mmem[i][j] = '0;
      end else if (mcyc[i] < mdepth[i]) begin
        mcyc[i]++;
        exp_done[i] = (mcyc[i] == mdepth[i]);
      end else begin
        wr_ok = w_en && (int'(w_addr) < mdepth[i]);
        if (r_en) begin
          if (int'(r_addr) >= mdepth[i]) begin
            exp_rd[i] = '0;
          end else begin
            old = mmem[i][r_addr];
`ifdef SRAM_RW_BYPASS_EN
            if (wr_ok && (w_addr == r_addr)) old = (old & ~bits) | (w_data & bits);
`endif
            exp_rd[i] = old;
          end
        end
        if (wr_ok) mmem[i][w_addr] = (mmem[i][w_addr] & ~bits) | (w_data & bits);
      end
    end
  endtask

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("init_done_d128", DW'(done_a), DW'(exp_done[0]));
    check("init_done_d100", DW'(done_b), DW'(exp_done[1]));
    check("rdata_d128", rd_a, exp_rd[0]);
    check("rdata_d100", rd_b, exp_rd[1]);
  endtask

  task automatic do_cycle(input logic rst, input logic re, input logic [AW-1:0] ra,
                          input logic we, input logic [AW-1:0] wa,
                          input logic [NL-1:0] m, input logic [DW-1:0] d);
    reset  = rst;
    r_en   = re;
    r_addr = ra;
    w_en   = we;
    w_addr = wa;
    w_mask = m;
    w_data = d;
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic rand_cycle(input logic rst);
    do_cycle(rst, 1'($urandom), AW'($urandom_range(0, 127)), 1'($urandom),
             AW'($urandom_range(0, 127)), NL'($urandom), rand_data());
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!done_a && n < 300) begin
      do_cycle(1'b0, 1'b1, AW'($urandom_range(0, 127)), 1'b1,
               AW'($urandom_range(0, 127)), '1, rand_data());
      n++;
    end
    check(name, DW'(n), DW'(128));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] exp_collide;

    model_step();
    repeat (3) begin
      @(negedge clock);
      compare_all();
    end
    check("reset_rdata", rd_a, '0);
    check("reset_done", DW'(done_a), '0);

    // Sweep with traffic: writes ignored, R0_data stays 0, done after 128 cycles.
    wait_init("init_latency");

    // Masked partial overwrite of entry 5.
    do_cycle(1'b0, 1'b0, '0, 1'b1, AW'(5), 19'h7FFFF, '1);
    do_cycle(1'b0, 1'b0, '0, 1'b1, AW'(5), 19'h00001, '0);
    do_cycle(1'b0, 1'b1, AW'(5), 1'b0, '0, '0, '0);
    check("rmw_addr5", rd_a, {{144{1'b1}}, 8'h00});

    // Read data holds while R0_en is low, even as entry 5 is rewritten.
    held = rd_a;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b0, 1'b0, AW'(5), 1'b1, AW'(5), '1, rand_data());
      check("hold_addr5", rd_a, held);
    end

    // Same-address collision on entry 9.
    do_cycle(1'b0, 1'b0, '0, 1'b1, AW'(9), '1, '0);
    do_cycle(1'b0, 1'b1, AW'(9), 1'b1, AW'(9), 19'h00001, DW'(8'hFF));
`ifdef SRAM_RW_BYPASS_EN
    exp_collide = DW'(8'hFF);
`else
    exp_collide = '0;
`endif
    check("collide_addr9", rd_a, exp_collide);

    // Out-of-range address on the DEPTH=100 instance.
    do_cycle(1'b0, 1'b0, '0, 1'b1, AW'(120), '1, '1);
    do_cycle(1'b0, 1'b1, AW'(120), 1'b0, '0, '0, '0);
    check("oor_read_d100", rd_b, '0);
    check("inrange_read_d128", rd_a, '1);

    // Reset mid-sweep discards earlier contents.
    do_cycle(1'b0, 1'b0, '0, 1'b1, AW'(3), '1, DW'(8'hAB));
    do_cycle(1'b0, 1'b1, AW'(3), 1'b0, '0, '0, '0);
    check("addr3_ab", rd_a, DW'(8'hAB));
    do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    check("reset_clears_rdata", rd_a, '0);
    repeat (40) rand_cycle(1'b0);
    do_cycle(1'b1, 1'b1, AW'(3), 1'b1, AW'(3), '1, '1);
    check("midsweep_done", DW'(done_a), '0);
    check("midsweep_rdata", rd_a, '0);
    wait_init("reinit_latency");
    do_cycle(1'b0, 1'b1, AW'(3), 1'b0, '0, '0, '0);
    check("addr3_cleared", rd_a, '0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_cycle($urandom_range(0, 999) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_init.md
SRAM_1R1W_INIT -- requirements
Module: sram_1r1w_init

Interface
REQ-001 SHALL expose parameter DATA_W, default 152, data width in bits.
REQ-002 SHALL expose parameter DEPTH, default 128, entry count; need not be a power of two.
REQ-003 SHALL expose parameter MASK_GRAN, default 8, bits per write-mask lane; DATA_W SHALL be a multiple of MASK_GRAN; NLANE = DATA_W/MASK_GRAN.
REQ-004 SHALL derive localparam ADDR_W = max(1, clog2(DEPTH)).
REQ-005 SHALL provide port clock, input, 1, sole clock, rising edge.
REQ-006 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide port R0_en, input, 1, read request.
REQ-008 SHALL provide port R0_addr, input, ADDR_W, read address.
REQ-009 SHALL provide port R0_data, output, DATA_W, read data.
REQ-010 SHALL provide port W0_en, input, 1, write request.
REQ-011 SHALL provide port W0_addr, input, ADDR_W, write address.
REQ-012 SHALL provide port W0_mask, input, NLANE, per-lane write enable.
REQ-013 SHALL provide port W0_data, input, DATA_W, write data.
REQ-014 SHALL provide port init_done, output, 1, high once the clear sweep is complete.

Function
REQ-015 SHALL implement state machine INIT -> IDLE; INIT entered on reset, IDLE entered when the sweep counter writes entry DEPTH-1.
REQ-016 In INIT, SHALL write all-zero to entry cnt each cycle, cnt incrementing 0..DEPTH-1; the sweep takes exactly DEPTH cycles after reset deassertion.
REQ-017 In INIT, SHALL ignore R0_en and W0_en; init_done SHALL be 0; R0_data SHALL hold 0.
REQ-018 In IDLE, init_done SHALL be 1, registered, asserted in the cycle after the final sweep write.
REQ-019 Write: when W0_en in IDLE, lane k of entry W0_addr SHALL take W0_data lane k iff W0_mask[k]=1; other lanes unchanged.
REQ-020 Read latency SHALL be 1 cycle: R0_en at edge N -> R0_data valid after edge N, stable until the next accepted read.
REQ-021 When R0_en=0, R0_data SHALL hold its last value; no random or garbage data.
REQ-022 Addresses >= DEPTH: writes SHALL be dropped; reads SHALL return all-zero.
REQ-023 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-024 Simultaneous read and write to the same address SHALL resolve per REQ-029/REQ-030.

Reset
REQ-025 Reset SHALL act asynchronously: state=INIT, cnt=0, init_done=0, R0_data=0 immediately on assertion.
REQ-026 Reset asserted mid-sweep or mid-operation SHALL abort all activity and restart the full sweep on deassertion; prior array contents SHALL be treated as lost.
REQ-027 Array storage itself SHALL NOT be reset directly; clearing SHALL happen only through the sweep.

Configuration
REQ-028 Macro SRAM_RW_BYPASS_EN SHALL select same-address read/write collision behaviour.
REQ-029 With SRAM_RW_BYPASS_EN defined, a collision SHALL return write-first data: enabled lanes from W0_data, other lanes from the old entry.
REQ-030 Without SRAM_RW_BYPASS_EN, a collision SHALL return read-first data: the entry contents before the write.

Verification
REQ-031 Default params; release reset, drive R0_en/W0_en every cycle -> init_done rises after exactly 128 cycles; writes are ignored and R0_data stays 0 during the sweep.
REQ-032 After init, write addr 5 with all-ones data and mask 0x7FFFF, then addr 5 with 0 data and mask 0x00001 -> next read of addr 5 returns all-ones except bits [7:0]=0.
REQ-033 Read addr 5, then idle 10 cycles with a write to addr 5 -> R0_data holds the old value until a new R0_en.
REQ-034 Same-cycle read and write addr 9, old 0, data 0xFF, mask lane 0 -> R0_data=0xFF with the bypass macro, 0 without it.
REQ-035 Set DEPTH=100 and write/read addr 120 -> write dropped, read returns 0; entries 0..99 unaffected.
REQ-036 Write addr 3=0xAB, assert reset mid-sweep at cnt=40, then release -> sweep restarts from 0, and after init_done a read of addr 3 returns 0.
